// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage data memory: MMIO offsets, STATUS bits, region type.
package mips_mem_pkg;

    localparam logic [15:0] MMIO_BASE_DEF = 16'hFFFF;

    localparam logic [15:0] OFS_CYCLE    = 16'h0000;
    localparam logic [15:0] OFS_GPIO_OUT = 16'h0004;
    localparam logic [15:0] OFS_GPIO_IN  = 16'h0008;
    localparam logic [15:0] OFS_CMP      = 16'h000C;
    localparam logic [15:0] OFS_STATUS   = 16'h0010;

    localparam int STAT_TIMER  = 0;
    localparam int STAT_BUSERR = 1;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_RAM  = 2'd1,
        RGN_MMIO = 2'd2
    } regionT;

    function automatic logic isMmioOfs(input logic [15:0] ofs);
        return ofs inside {OFS_CYCLE, OFS_GPIO_OUT, OFS_GPIO_IN, OFS_CMP, OFS_STATUS};
    endfunction

endpackage

// File: rtl/mips_mmio_regs.sv
// MMIO register block: free-running cycle counter, timer compare, GPIO, input synchronizer,
// sticky STATUS bits and the MMIO read mux.
module mips_mmio_regs
    import mips_mem_pkg::*;
#(
    parameter int GPIO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [15:0]       ofs,
    input  logic [31:0]       wrData,
    input  logic              busErrSet,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [31:0]       rdData,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timerIrq,
    output logic              busErr
);

    logic [31:0]       cycleCnt;
    logic [31:0]       cmpReg;
    logic [GPIO_W-1:0] gpioOutReg;
    logic [GPIO_W-1:0] syncA;
    logic [GPIO_W-1:0] syncB;
    logic [1:0]        status;
    logic [1:0]        w1cMask;
    logic [1:0]        setMask;

    assign w1cMask = (wrEn && ofs == OFS_STATUS) ? wrData[1:0] : 2'b00;
    assign setMask[STAT_TIMER]  = (cycleCnt == cmpReg);
    assign setMask[STAT_BUSERR] = busErrSet;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt   <= '0;
            cmpReg     <= '1;
            gpioOutReg <= '0;
            syncA      <= '0;
            syncB      <= '0;
            status     <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            syncA    <= gpio_in;
            syncB    <= syncA;
            // new events take priority over a same-cycle W1C
            status   <= (status & ~w1cMask) | setMask;
            if (wrEn && ofs == OFS_GPIO_OUT)
                gpioOutReg <= wrData[GPIO_W-1:0];
            if (wrEn && ofs == OFS_CMP)
                cmpReg <= wrData;
        end
    end

    always_comb begin
        rdData = '0;
        case (ofs)
            OFS_CYCLE:    rdData = cycleCnt;
            OFS_GPIO_OUT: rdData = 32'(gpioOutReg);
            OFS_GPIO_IN:  rdData = 32'(syncB);
            OFS_CMP:      rdData = cmpReg;
            OFS_STATUS:   rdData = {30'd0, status};
            default:      rdData = '0;
        endcase
    end

    assign gpio_out = gpioOutReg;
    assign timerIrq = status[STAT_TIMER];
    assign busErr   = status[STAT_BUSERR];

endmodule

// File: rtl/mips_data_mem.sv
// M-stage data responder: address decode, word RAM with combinational read, MMIO block and
// final load-data mux. Every access completes in the cycle it is presented.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter int          GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [31:0]       EXResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0] ram [DEPTH];

    regionT      region;
    logic        aligned;
    logic        access;
    logic        badAccess;
    logic        ramWe;
    logic        mmioWe;
    logic        loadOk;
    logic [31:0] mmioRdata;

    always_comb begin
        region = RGN_NONE;
        if (EXResultM < RAM_BYTES)
            region = RGN_RAM;
        else if (EXResultM[31:16] == MMIO_BASE && isMmioOfs(EXResultM[15:0]))
            region = RGN_MMIO;
    end

    assign aligned   = (EXResultM[1:0] == 2'b00);
    assign access    = (MemReadM || MemWriteM) && !rst;
    assign badAccess = access && (!aligned || region == RGN_NONE);
    assign ramWe     = MemWriteM && !rst && aligned && region == RGN_RAM;
    assign mmioWe    = MemWriteM && !rst && aligned && region == RGN_MMIO;
    // a simultaneous read+write is a store, so it never returns data
    assign loadOk    = MemReadM && !MemWriteM && !rst && aligned;

    always_ff @(posedge clk) begin
        if (ramWe)
            ram[EXResultM[AW+1:2]] <= WriteDataM;
    end

    mips_mmio_regs #(
        .GPIO_W (GPIO_W)
    ) uMmio (
        .clk       (clk),
        .rst       (rst),
        .wrEn      (mmioWe),
        .ofs       (EXResultM[15:0]),
        .wrData    (WriteDataM),
        .busErrSet (badAccess),
        .gpio_in   (gpio_in),
        .rdData    (mmioRdata),
        .gpio_out  (gpio_out),
        .timerIrq  (timer_irq),
        .busErr    (bus_err)
    );

    always_comb begin
        ReadDataM = '0;
        if (loadOk) begin
            case (region)
                RGN_RAM:  ReadDataM = ram[EXResultM[AW+1:2]];
                RGN_MMIO: ReadDataM = mmioRdata;
                default:  ReadDataM = '0;
            endcase
        end
    end

endmodule
